// File: rtl/input_conditioner.sv
// Synchronises switch/button inputs, debounces enter and freezes the switch byte per accepted press.
// Latency DEBOUNCE_CYCLES+3 edges from a new button level; no backpressure, outputs free-running.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] switchIn,
  input  logic       enterIn,
  output logic [7:0] switch,
  output logic       enter,
  output logic       enterPulse,
  output logic [7:0] pressCount
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_meta, btn_s;
  logic [7:0]       sw_meta, sw_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             enter_d, pulse_d;
  logic [7:0]       switch_d, count_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      sw_meta  <= 8'h00;
      sw_s     <= 8'h00;
    end else begin
      btn_meta <= enterIn;
      btn_s    <= btn_meta;
      sw_meta  <= switchIn;
      sw_s     <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The debounced level follows the state being entered, so it is registered with it.
  always_comb begin
    enter_d  = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    pulse_d  = accept;
    switch_d = accept ? sw_s : switch;
    count_d  = accept ? pressCount + 8'd1 : pressCount;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enter      <= 1'b0;
      enterPulse <= 1'b0;
      switch     <= 8'h00;
      pressCount <= 8'h00;
    end else begin
      enter      <= enter_d;
      enterPulse <= pulse_d;
      switch     <= switch_d;
      pressCount <= count_d;
    end
  end

endmodule
